// File: rtl/project_pwm_pkg.sv
// Shared encodings for the PWM shadow-load block: FSM states, load events,
// shadow addresses and ctrl field positions.
package project_pwm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_LOAD  = 2'd2
   } load_state_t;

   localparam logic [1:0] LOAD_SEL_IMMEDIATE = 2'b00;
   localparam logic [1:0] LOAD_SEL_ZERO      = 2'b01;
   localparam logic [1:0] LOAD_SEL_PERIOD    = 2'b10;
   localparam logic [1:0] LOAD_SEL_SYNC      = 2'b11;

   localparam logic [1:0] ADDR_PERIOD    = 2'd0;
   localparam logic [1:0] ADDR_COMPARE_A = 2'd1;
   localparam logic [1:0] ADDR_COMPARE_B = 2'd2;
   localparam logic [1:0] ADDR_CTRL      = 2'd3;

   localparam int CTRL_MODE_LSB     = 0;
   localparam int CTRL_SYNC_SEL_LSB = 2;
   localparam int CTRL_SYNC_EN_BIT  = 4;
   localparam int CTRL_W            = 5;

   typedef struct packed {
      logic       sync_en;
      logic [1:0] sync_sel;
      logic [1:0] mode;
   } ctrl_t;

   // Only the low CTRL_W bits of a ctrl write carry meaning; the rest are dropped by the caller.
   function automatic ctrl_t unpack_ctrl(input logic [CTRL_W-1:0] bits);
      ctrl_t c;
      c.mode     = bits[CTRL_MODE_LSB +: 2];
      c.sync_sel = bits[CTRL_SYNC_SEL_LSB +: 2];
      c.sync_en  = bits[CTRL_SYNC_EN_BIT];
      return c;
   endfunction

endpackage

// File: rtl/project_shadow_load_ctrl_if.sv
// Host write port into the shadow register file.
// A write transfers on a rising clock edge where i_wr_valid and o_wr_ready are both 1;
// addr/data must be stable while i_wr_valid is high, and ready never depends on valid.
interface project_shadow_load_ctrl_if;
   logic        i_wr_valid;
   logic        o_wr_ready;
   logic [1:0]  i_wr_addr;
   logic [15:0] i_wr_data;

   modport master (output i_wr_valid, i_wr_addr, i_wr_data, input o_wr_ready);
   modport slave  (input i_wr_valid, i_wr_addr, i_wr_data, output o_wr_ready);
endinterface

// File: rtl/project_load_event_detect.sv
// Combinational selection of the armed transfer's load event.
module project_load_event_detect
   import project_pwm_pkg::*;
(
   input  logic [1:0]  load_sel,
   input  logic [15:0] counter_next,
   input  logic [15:0] period,
   input  logic        sync_in,
   output logic        load_event
);

   always_comb begin
      load_event = 1'b0;
      case (load_sel)
         LOAD_SEL_IMMEDIATE: load_event = 1'b1;
         LOAD_SEL_ZERO:      load_event = (counter_next == 16'd0);
         // Compared against the active period, not a pending shadow value.
         LOAD_SEL_PERIOD:    load_event = (counter_next == period);
         LOAD_SEL_SYNC:      load_event = sync_in;
         default:            load_event = 1'b0;
      endcase
   end

endmodule

// File: rtl/project_shadow_load_ctrl.sv
// Shadow/active register pair for a PWM channel with event-timed atomic transfer.
// Optional sticky load flag enabled by defining PROJECT_LOAD_IRQ_EN.
module project_shadow_load_ctrl
   import project_pwm_pkg::*;
(
   input  logic                             i_clk,
   input  logic                             i_reset,
   project_shadow_load_ctrl_if.slave        wr_bus,
   input  logic                             i_commit,
   input  logic                             i_abort,
   input  logic [1:0]                       i_load_sel,
   input  logic [15:0]                      i_counter_next,
   input  logic                             i_sync_in,
   input  logic                             i_irq_clr,
   output logic [15:0]                      o_period,
   output logic [15:0]                      o_compare_a,
   output logic [15:0]                      o_compare_b,
   output logic [1:0]                       o_mode,
   output logic [1:0]                       o_sync_sel,
   output logic                             o_sync_en,
   output logic                             o_pending,
   output logic                             o_load_pulse,
   output logic                             o_load_irq,
   output logic [1:0]                       o_dbg_state
);

   load_state_t state_q, state_d;
   logic [1:0]  load_sel_q;
   logic        load_event;
   logic        load_now;
   logic        wr_fire;

   logic [15:0] period_sh, compare_a_sh, compare_b_sh;
   ctrl_t       ctrl_sh, ctrl_act;

   project_load_event_detect u_event (
      .load_sel     (load_sel_q),
      .counter_next (i_counter_next),
      .period       (o_period),
      .sync_in      (i_sync_in),
      .load_event   (load_event)
   );

   assign wr_fire = wr_bus.i_wr_valid && (state_q == ST_IDLE);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Abort has priority over a coincident load event.
   always_comb begin
      state_d  = state_q;
      load_now = 1'b0;
      case (state_q)
         ST_IDLE:  if (i_commit) state_d = ST_ARMED;
         ST_ARMED: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (load_event) begin
               state_d  = ST_LOAD;
               load_now = 1'b1;
            end
         end
         ST_LOAD:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) load_sel_q <= LOAD_SEL_IMMEDIATE;
      else if ((state_q == ST_IDLE) && i_commit) load_sel_q <= i_load_sel;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         period_sh    <= '0;
         compare_a_sh <= '0;
         compare_b_sh <= '0;
         ctrl_sh      <= '0;
      end else if (wr_fire) begin
         case (wr_bus.i_wr_addr)
            ADDR_PERIOD:    period_sh    <= wr_bus.i_wr_data;
            ADDR_COMPARE_A: compare_a_sh <= wr_bus.i_wr_data;
            ADDR_COMPARE_B: compare_b_sh <= wr_bus.i_wr_data;
            ADDR_CTRL:      ctrl_sh      <= unpack_ctrl(wr_bus.i_wr_data[CTRL_W-1:0]);
            default:        ctrl_sh      <= ctrl_sh;
         endcase
      end
   end

   // All active registers move together on the load edge.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_period    <= '0;
         o_compare_a <= '0;
         o_compare_b <= '0;
         ctrl_act    <= '0;
      end else if (load_now) begin
         o_period    <= period_sh;
         o_compare_a <= compare_a_sh;
         o_compare_b <= compare_b_sh;
         ctrl_act    <= ctrl_sh;
      end
   end

   assign o_mode            = ctrl_act.mode;
   assign o_sync_sel        = ctrl_act.sync_sel;
   assign o_sync_en         = ctrl_act.sync_en;
   assign wr_bus.o_wr_ready = (state_q == ST_IDLE);
   assign o_pending         = (state_q == ST_ARMED);
   assign o_load_pulse      = (state_q == ST_LOAD);
   assign o_dbg_state       = state_q;

`ifdef PROJECT_LOAD_IRQ_EN
   logic irq_q;

   // Set on the edge entering LOAD wins over a same-cycle clear.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)        irq_q <= 1'b0;
      else if (load_now)  irq_q <= 1'b1;
      else if (i_irq_clr) irq_q <= 1'b0;
   end

   assign o_load_irq = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = i_irq_clr;
   assign o_load_irq     = 1'b0;
`endif

endmodule

// File: tb/tb_project_shadow_load_ctrl.sv
// Bench for project_shadow_load_ctrl: directed scenarios then randomized traffic
// checked against a register-array model of the shadow/active transfer rules.
`timescale 1ns/1ps
module tb_project_shadow_load_ctrl;

`ifdef PROJECT_LOAD_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_commit, i_abort, i_sync_in, i_irq_clr;
   logic [1:0]  i_load_sel;
   logic [15:0] i_counter_next;
   logic [15:0] o_period, o_compare_a, o_compare_b;
   logic [1:0]  o_mode, o_sync_sel;
   logic        o_sync_en, o_pending, o_load_pulse, o_load_irq;
   logic [1:0]  unused_dbg_state;

   project_shadow_load_ctrl_if wr_bus();

   project_shadow_load_ctrl dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .wr_bus         (wr_bus),
      .i_commit       (i_commit),
      .i_abort        (i_abort),
      .i_load_sel     (i_load_sel),
      .i_counter_next (i_counter_next),
      .i_sync_in      (i_sync_in),
      .i_irq_clr      (i_irq_clr),
      .o_period       (o_period),
      .o_compare_a    (o_compare_a),
      .o_compare_b    (o_compare_b),
      .o_mode         (o_mode),
      .o_sync_sel     (o_sync_sel),
      .o_sync_en      (o_sync_en),
      .o_pending      (o_pending),
      .o_load_pulse   (o_load_pulse),
      .o_load_irq     (o_load_irq),
      .o_dbg_state    (unused_dbg_state)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: shadow and active register files indexed by write address.
   logic [15:0] sh [4];
   logic [15:0] act [4];
   bit          m_armed, m_loading, m_irq;
   logic [1:0]  m_sel;
   logic [15:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         sh[k]  = '0;
         act[k] = '0;
      end
      m_armed = 0; m_loading = 0; m_irq = 0; m_sel = 2'd0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      bit idle, evt, load;
      idle = !m_armed && !m_loading;
      case (m_sel)
         2'd0:    evt = 1'b1;
         2'd1:    evt = (i_counter_next == 16'd0);
         2'd2:    evt = (i_counter_next == act[0]);
         default: evt = i_sync_in;
      endcase
      load = m_armed && !i_abort && evt;
      if (idle && wr_bus.i_wr_valid) sh[wr_bus.i_wr_addr] = wr_bus.i_wr_data;
      if (load) begin
         for (int k = 0; k < 4; k++) act[k] = sh[k];
         exp_q.push_back(sh[0]);
      end
      if (IRQ_EN) begin
         if (load)           m_irq = 1'b1;
         else if (i_irq_clr) m_irq = 1'b0;
      end
      if (idle && i_commit) begin
         m_armed = 1'b1;
         m_sel   = i_load_sel;
      end else if (m_armed && (i_abort || evt)) begin
         m_armed = 1'b0;
      end
      m_loading = load;
   endtask

   task automatic check_all();
      logic [15:0] exp_p;
      check("wr_ready",   wr_bus.o_wr_ready, 32'(!m_armed && !m_loading));
      check("pending",    o_pending,    32'(m_armed));
      check("load_pulse", o_load_pulse, 32'(m_loading));
      check("period",     o_period,     act[0]);
      check("compare_a",  o_compare_a,  act[1]);
      check("compare_b",  o_compare_b,  act[2]);
      check("mode",       o_mode,       act[3][1:0]);
      check("sync_sel",   o_sync_sel,   act[3][3:2]);
      check("sync_en",    o_sync_en,    act[3][4]);
      check("load_irq",   o_load_irq,   32'(m_irq));
      if (m_loading && exp_q.size() > 0) begin
         exp_p = exp_q.pop_front();
         check("sb_period", o_period, exp_p);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      wr_bus.i_wr_valid = 0; wr_bus.i_wr_addr = 0; wr_bus.i_wr_data = 0;
      i_commit = 0; i_abort = 0; i_sync_in = 0; i_irq_clr = 0;
      i_load_sel = 0; i_counter_next = 16'd7;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      #2;
      model_reset();
      check_all();
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      check_all();
   endtask

   task automatic write(input logic [1:0] addr, input logic [15:0] data);
      wr_bus.i_wr_valid = 1; wr_bus.i_wr_addr = addr; wr_bus.i_wr_data = data;
      step();
      wr_bus.i_wr_valid = 0;
   endtask

   task automatic commit(input logic [1:0] sel);
      i_commit = 1; i_load_sel = sel;
      step();
      i_commit = 0;
   endtask

   initial begin
      idle_inputs();
      i_reset = 1'b1;
      #1;
      do_reset();
      check("rst_period", o_period, 16'd0);
      check("rst_ready",  wr_bus.o_wr_ready, 1'b1);

      // Immediate load: pending at N+1 only, pulse and new period at N+2.
      write(2'd0, 16'd100);
      commit(2'd0);
      check("imm_pending_n1", o_pending, 1'b1);
      check("imm_pulse_n1",   o_load_pulse, 1'b0);
      step();
      check("imm_pulse_n2",   o_load_pulse, 1'b1);
      check("imm_period_n2",  o_period, 16'd100);
      check("imm_pending_n2", o_pending, 1'b0);
      step();

      // Counter-zero load.
      write(2'd2, 16'd40);
      commit(2'd1);
      for (int c = 5; c >= 0; c--) begin
         i_counter_next = 16'(c);
         step();
         check("zero_pulse", o_load_pulse, 32'(c == 0));
      end
      check("zero_cmp_b", o_compare_b, 16'd40);
      i_counter_next = 16'd7;
      step();

      // Period-match load compares against the active period of 10.
      write(2'd0, 16'd10);
      commit(2'd0);
      step(); step();
      write(2'd0, 16'd20);
      commit(2'd2);
      for (int c = 5; c <= 12; c++) begin
         i_counter_next = 16'(c);
         step();
         check("period_pulse", o_load_pulse, 32'(c == 10));
      end
      check("period_new", o_period, 16'd20);

      // Abort beats a same-cycle sync event; shadow survives.
      write(2'd1, 16'h1234);
      commit(2'd3);
      i_abort = 1; i_sync_in = 1;
      step();
      i_abort = 0; i_sync_in = 0;
      check("abort_ready", wr_bus.o_wr_ready, 1'b1);
      check("abort_pulse", o_load_pulse, 1'b0);
      check("abort_cmp_a_still_old", o_compare_a, 16'd0);
      step();
      commit(2'd0);
      step();
      check("abort_shadow_kept", o_compare_a, 16'h1234);
      step();

      // Write and commit in the same cycle; flag set then cleared.
      wr_bus.i_wr_valid = 1; wr_bus.i_wr_addr = 2'd3; wr_bus.i_wr_data = 16'hffff;
      commit(2'd0);
      wr_bus.i_wr_valid = 0;
      step();
      check("same_cycle_mode", o_mode, 2'd3);
      check("same_cycle_sync_sel", o_sync_sel, 2'd3);
      check("same_cycle_sync_en", o_sync_en, 1'b1);
      check("irq_set", o_load_irq, IRQ_EN);
      i_irq_clr = 1;
      step();
      i_irq_clr = 0;
      check("irq_clr", o_load_irq, 1'b0);
      commit(2'd0);
      i_irq_clr = 1;
      step();
      i_irq_clr = 0;
      check("irq_set_wins", o_load_irq, IRQ_EN);
      step();

      // Reset while armed discards the transfer.
      commit(2'd3);
      check("armed_before_rst", o_pending, 1'b1);
      do_reset();
      check("rst_armed_period", o_period, 16'd0);
      check("rst_armed_pending", o_pending, 1'b0);
      i_sync_in = 1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rst_no_pulse", o_load_pulse, 1'b0);
      end
      i_sync_in = 0;

      // Randomized traffic.
      for (int n = 0; n < 800; n++) begin
         wr_bus.i_wr_valid = ($urandom_range(0, 2) == 0);
         wr_bus.i_wr_addr  = 2'($urandom_range(0, 3));
         wr_bus.i_wr_data  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         i_commit          = ($urandom_range(0, 3) == 0);
         i_abort           = ($urandom_range(0, 7) == 0);
         i_load_sel        = 2'($urandom_range(0, 3));
         i_counter_next    = 16'($urandom_range(0, 15));
         i_sync_in         = ($urandom_range(0, 3) == 0);
         i_irq_clr         = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 199) == 0) do_reset();
         else step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/project_shadow_load_ctrl.md
PROJECT_SHADOW_LOAD_CTRL -- requirements
Module: project_shadow_load_ctrl

Interface
REQ-001 SHALL have ports: i_clk  input  1  sole clock, rising edge.
REQ-002 SHALL have: i_reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: i_wr_valid  input  1  host write request; o_wr_ready  output  1  write accepted when valid&ready.
REQ-004 SHALL have: i_wr_addr  input  2  shadow select (0 period, 1 compare_a, 2 compare_b, 3 ctrl); i_wr_data  input  16  write data.
REQ-005 SHALL have: i_commit  input  1  request shadow-to-active transfer; i_abort  input  1  cancel armed transfer.
REQ-006 SHALL have: i_load_sel  input  2  load event (00 immediate, 01 counter zero, 10 counter period, 11 external sync).
REQ-007 SHALL have: i_counter_next  input  16  master counter next value; i_sync_in  input  1  master sync pulse.
REQ-008 SHALL have: o_period, o_compare_a, o_compare_b  output  16 each  active values to counter/comparators.
REQ-009 SHALL have: o_mode  output  2, o_sync_sel  output  2, o_sync_en  output  1  active ctrl fields.
REQ-010 SHALL have: o_pending  output  1  transfer armed; o_load_pulse  output  1  one-cycle load strobe; o_load_irq  output  1  sticky load flag; i_irq_clr  input  1  clears flag.

Function
REQ-011 SHALL hold shadow registers: period, compare_a, compare_b (16 b), ctrl (data[1:0] mode, [3:2] sync_sel, [4] sync_en, [15:5] ignored).
REQ-012 SHALL implement FSM IDLE -> ARMED -> LOAD -> IDLE.
REQ-013 o_wr_ready SHALL be 1 only in IDLE; accepted write updates addressed shadow on that edge.
REQ-014 Write and i_commit in same IDLE cycle: write SHALL land in shadow and be included in the transfer.
REQ-015 i_commit in IDLE SHALL latch i_load_sel into internal load_sel and enter ARMED; o_pending=1 in ARMED.
REQ-016 Event in ARMED: immediate=always; zero=(i_counter_next==0); period=(i_counter_next==o_period, active value); sync=i_sync_in.
REQ-017 On edge where ARMED and event true, all active registers SHALL load all shadow registers atomically; state -> LOAD.
REQ-018 o_load_pulse SHALL be 1 exactly in LOAD cycle (immediate: commit cycle N, pulse and new outputs at N+2).
REQ-019 i_abort in ARMED SHALL return to IDLE without load, shadow retained; abort and event same cycle: abort wins.
REQ-020 i_commit/i_abort in ARMED/LOAD and i_abort in IDLE SHALL be ignored.
REQ-021 o_load_irq SHALL set on entry to LOAD, clear on i_irq_clr; set and clear same cycle: set wins.

Reset
REQ-022 Reset SHALL force IDLE, all shadow and active registers 0, o_pending=0, o_load_pulse=0, o_load_irq=0, o_wr_ready=1 after release.
REQ-023 Reset asserted while ARMED SHALL discard armed transfer; no load pulse after release.

Configuration
REQ-024 Macro PROJECT_LOAD_IRQ_EN defined: o_load_irq behaves per REQ-021.
REQ-025 Macro undefined: o_load_irq SHALL be constant 0, i_irq_clr unused, no flag flop.

Structure
REQ-026 Shared package project_pwm_pkg SHALL hold FSM state encoding, load_sel encodings, shadow address encodings, ctrl bit positions.
REQ-027 One sub-module project_load_event_detect SHALL compute event from load_sel, i_counter_next, o_period, i_sync_in (combinational).

Verification
REQ-028 Write period=100, commit load_sel=00 at cycle N -> o_load_pulse and o_period=100 at N+2, o_pending high at N+1 only.
REQ-029 Write compare_b=40, commit load_sel=01, counter_next runs 5..0 -> load on edge where counter_next==0, no earlier.
REQ-030 Active period=10, commit load_sel=10 with new period 20 -> load when counter_next==10, o_period becomes 20.
REQ-031 Commit load_sel=11, assert i_abort and i_sync_in same cycle -> no load, IDLE, o_wr_ready=1, shadow unchanged.
REQ-032 Assert i_reset while ARMED -> all outputs 0, no later o_load_pulse; with PROJECT_LOAD_IRQ_EN, irq set after load, cleared by i_irq_clr.
